fft_bfly_sched_64: RTL and testbench

// - Sequencer for the in-place radix-2 DIT 64-point FFT core.
// - Walks all LOG2N stages x N/2 butterflies.
// - Per butterfly it issues the operand pair addresses (addr_a, addr_b) to the

---
 rtl/fft_bfly_sched_64.sv | 165 ++++++++++++++++
 tb/tb_fft_bfly_sched_64.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sched_64.sv
`default_nettype none
// ============================================================================
// Module      : fft_bfly_sched_64
// Description : Butterfly sequencer for an in-place radix-2 DIT FFT.
//               Walks LOG2N stages of N/2 butterflies. For each butterfly it
//               presents the two sample-RAM operand addresses and the
//               twiddle-ROM index on a valid/ready interface. A programmable
//               idle gap between stages lets the datapath finish writing
//               stage s back before stage s+1 starts reading.
// Ports       : clk, rst          clock, synchronous active-high reset
//               start, abort      begin a transform / return to IDLE at once
//               busy, done        RUN/DRAIN/DONE indicator, end-of-run pulse
//               bfly_valid/ready  descriptor handshake
//               stage, addr_a, addr_b, tw_addr, last  butterfly descriptor
// Revision    : 1.0  initial release
// ============================================================================
module fft_bfly_sched_64 #(
   parameter int N         = 64,
   parameter int LOG2N     = 6,
   parameter int STAGE_GAP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             bfly_valid,
   input  logic             bfly_ready,
   output logic [2:0]       stage,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             last
);

   localparam int KW       = LOG2N - 1;
   localparam int GW       = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int GAP_LAST = (STAGE_GAP > 0) ? STAGE_GAP - 1 : 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_r, state_n;
   logic [2:0]      stage_r, stage_n;
   logic [KW-1:0]   k_r, k_n;
   logic [GW-1:0]   gap_r, gap_n;

   logic            hs;
   logic            k_last;
   logic            s_last;

   assign hs     = (state_r == RUN) & bfly_ready;
   assign k_last = (k_r == KW'(N/2 - 1));
   assign s_last = (stage_r == 3'(LOG2N - 1));

   // ---------------------------------------------------------------------
   // State and counter registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         stage_r <= '0;
         k_r     <= '0;
         gap_r   <= '0;
      end else begin
         state_r <= state_n;
         stage_r <= stage_n;
         k_r     <= k_n;
         gap_r   <= gap_n;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_n = state_r;
      stage_n = stage_r;
      k_n     = k_r;
      gap_n   = gap_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               stage_n = '0;
               k_n     = '0;
            end
         end
         RUN: begin
            if (hs) begin
               if (k_last) begin
                  k_n = '0;
                  if (s_last) begin
                     state_n = DONE;
                     stage_n = '0;
                  end else begin
                     stage_n = stage_r + 3'd1;
                     gap_n   = '0;
                     // With no gap the next stage follows without a bubble.
                     state_n = (STAGE_GAP > 0) ? DRAIN : RUN;
                  end
               end else begin
                  k_n = k_r + KW'(1);
               end
            end
         end
         DRAIN: begin
            if (gap_r == GW'(GAP_LAST)) begin
               state_n = RUN;
               gap_n   = '0;
            end else begin
               gap_n = gap_r + GW'(1);
            end
         end
         DONE: begin
            // start is deliberately ignored here
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // abort overrides everything, including a same-cycle start
      if (abort) begin
         state_n = IDLE;
         stage_n = '0;
         k_n     = '0;
         gap_n   = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Descriptor decode from the registered (stage, k) pair.
   // Splitting k at bit s and inserting a zero there gives addr_a; the
   // lower leg sits exactly half above it. The twiddle index is the
   // in-group position scaled to the N/2 ROM.
   // ---------------------------------------------------------------------
   logic [LOG2N-1:0] kx, half, mask, a_calc, b_calc;
   logic [KW-1:0]    pos, tw_calc;

   always_comb begin
      kx      = {1'b0, k_r};
      half    = LOG2N'(1) << stage_r;
      mask    = half - LOG2N'(1);
      a_calc  = ((kx & ~mask) << 1) | (kx & mask);
      b_calc  = a_calc + half;
      pos     = k_r & mask[KW-1:0];
      tw_calc = pos << (3'(LOG2N - 1) - stage_r);
   end

   assign bfly_valid = (state_r == RUN);
   assign busy       = (state_r != IDLE);
   assign done       = (state_r == DONE);
   assign stage      = stage_r;
   // Addresses read as zero whenever no descriptor is offered.
   assign addr_a     = bfly_valid ? a_calc  : '0;
   assign addr_b     = bfly_valid ? b_calc  : '0;
   assign tw_addr    = bfly_valid ? tw_calc : '0;
   assign last       = bfly_valid & s_last & k_last;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_sched_64.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bfly_sched_64
// Description : Self-checking bench for fft_bfly_sched_64. Two instances are
//               used: one with a 4-cycle stage gap and one with no gap; a
//               select signal routes stimulus and observation to one of them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fft_bfly_sched_64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, abort, bfly_ready, sel;

   logic       busy0, done0, valid0, last0, busy1, done1, valid1, last1;
   logic [2:0] stage0, stage1;
   logic [5:0] a0, b0, a1, b1;
   logic [4:0] tw0, tw1;

   logic start0, start1, abort0, abort1;
   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign abort0 = abort & ~sel;
   assign abort1 = abort & sel;

   fft_bfly_sched_64 #(.N(64), .LOG2N(6), .STAGE_GAP(4)) dut_gap4 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0),
      .busy(busy0), .done(done0), .bfly_valid(valid0), .bfly_ready(bfly_ready),
      .stage(stage0), .addr_a(a0), .addr_b(b0), .tw_addr(tw0), .last(last0));

   fft_bfly_sched_64 #(.N(64), .LOG2N(6), .STAGE_GAP(0)) dut_gap0 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .busy(busy1), .done(done1), .bfly_valid(valid1), .bfly_ready(bfly_ready),
      .stage(stage1), .addr_a(a1), .addr_b(b1), .tw_addr(tw1), .last(last1));

   logic       busy, done, valid, last;
   logic [2:0] stage;
   logic [5:0] addr_a, addr_b;
   logic [4:0] tw_addr;
   assign busy    = sel ? busy1  : busy0;
   assign done    = sel ? done1  : done0;
   assign valid   = sel ? valid1 : valid0;
   assign last    = sel ? last1  : last0;
   assign stage   = sel ? stage1 : stage0;
   assign addr_a  = sel ? a1     : a0;
   assign addr_b  = sel ? b1     : b0;
   assign tw_addr = sel ? tw1    : tw0;

   int checks   = 0;
   int failures = 0;

   // Reference butterfly order: plain arithmetic on (stage, k).
   int es[192], ea[192], eb[192], etw[192];
   int cap_a[192], cap_b[192], cap_tw[192];
   int hs_total;

   function automatic void build_model();
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < 32; k++) begin
            int half, grp, pos, i;
            half = 1 << s;
            grp  = k / half;
            pos  = k % half;
            i    = s * 32 + k;
            es[i]  = s;
            ea[i]  = grp * 2 * half + pos;
            eb[i]  = ea[i] + half;
            etw[i] = pos * (32 / half);
         end
      end
   endfunction

   // Runs one transform on the selected instance and checks it cycle by
   // cycle. Cycle 0 is the cycle in which start is sampled.
   task automatic run_seq(input int gap, input bit rnd, input int abort_hs,
                          input bit extra_start);
      int  h, c, per, done_c;
      bit  fin_prev, prev_stall, after_done, aborted, exp_v;
      logic [5:0] pa, pb;
      logic [4:0] ptw;
      logic [2:0] ps;
      h = 0; fin_prev = 0; prev_stall = 0; after_done = 0; aborted = 0;
      pa = '0; pb = '0; ptw = '0; ps = '0;
      per = 32 + gap;
      done_c = 6 * per - gap + 1;
      @(negedge clk);
      start = 1'b1; abort = 1'b0; bfly_ready = 1'b1;
      @(posedge clk);
      c = 1;
      while (c < 3000) begin
         @(negedge clk);
         abort      = 1'b0;
         bfly_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start      = extra_start && !after_done && ((c % 23 == 7) || done);
         if (aborted) begin
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
               failures++;
               $display("FAIL abort_idle: busy=%b valid=%b done=%b want 000",
                        busy, valid, done);
            end
            start = 1'b0;
            for (int j = 0; j < 40; j++) begin
               @(negedge clk);
               checks++;
               if (done !== 1'b0 || busy !== 1'b0) begin
                  failures++;
                  $display("FAIL abort_nodone: done=%b busy=%b want 0 0", done, busy);
               end
            end
            break;
         end
         if (abort_hs >= 0 && h == abort_hs && valid === 1'b1) begin
            abort = 1'b1; bfly_ready = 1'b0; aborted = 1'b1;
         end
         if (!rnd) begin
            exp_v = ((c - 1) < 6 * per - gap) && (((c - 1) % per) < 32);
            checks++;
            if (valid !== exp_v) begin
               failures++;
               $display("FAIL valid_timing: cycle %0d valid=%b want %b", c, valid, exp_v);
            end
            checks++;
            if (done !== (c == done_c) || busy !== (c <= done_c)) begin
               failures++;
               $display("FAIL done_busy_timing: cycle %0d done=%b busy=%b want %b %b",
                        c, done, busy, (c == done_c), (c <= done_c));
            end
         end
         checks++;
         if (done !== fin_prev) begin
            failures++;
            $display("FAIL done_after_last: cycle %0d done=%b want %b", c, done, fin_prev);
         end
         if (valid === 1'b1) begin
            checks++;
            if (h >= 192) begin
               failures++;
               $display("FAIL extra_valid: cycle %0d handshake count %0d want <192", c, h);
            end else if (stage !== 3'(es[h]) || addr_a !== 6'(ea[h]) ||
                         addr_b !== 6'(eb[h]) || tw_addr !== 5'(etw[h]) ||
                         last !== (h == 191)) begin
               failures++;
               $display("FAIL descriptor[%0d]: s=%0d a=%0d b=%0d tw=%0d last=%b want s=%0d a=%0d b=%0d tw=%0d last=%b",
                        h, stage, addr_a, addr_b, tw_addr, last,
                        es[h], ea[h], eb[h], etw[h], (h == 191));
            end
         end
         if (prev_stall) begin
            checks++;
            if (valid !== 1'b1 || stage !== ps || addr_a !== pa ||
                addr_b !== pb || tw_addr !== ptw) begin
               failures++;
               $display("FAIL stall_hold: v=%b s=%0d a=%0d b=%0d tw=%0d want 1 %0d %0d %0d %0d",
                        valid, stage, addr_a, addr_b, tw_addr, ps, pa, pb, ptw);
            end
         end
         if (after_done) begin
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
               failures++;
               $display("FAIL idle_after_done: busy=%b valid=%b want 0 0", busy, valid);
            end
            break;
         end
         if (done === 1'b1) after_done = 1'b1;
         fin_prev   = 1'b0;
         prev_stall = valid && !bfly_ready;
         ps = stage; pa = addr_a; pb = addr_b; ptw = tw_addr;
         if (valid === 1'b1 && bfly_ready && h < 192) begin
            cap_a[h] = addr_a; cap_b[h] = addr_b; cap_tw[h] = tw_addr;
            h++;
            if (h == 192) fin_prev = 1'b1;
         end
         @(posedge clk);
         c++;
      end
      hs_total = h;
      start = 1'b0; abort = 1'b0; bfly_ready = 1'b1;
      checks++;
      if (c >= 3000) begin
         failures++;
         $display("FAIL run_timeout: %0d cycles without completion", c);
      end
      if (abort_hs < 0) begin
         checks++;
         if (h != 192) begin
            failures++;
            $display("FAIL handshake_count: got %0d want 192", h);
         end
      end
   endtask

   task automatic test_reset();
      sel = 1'b0; rst = 1'b1; abort = 1'b0; bfly_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = i[0];
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ((d ? busy1 : busy0) !== 1'b0 || (d ? done1 : done0) !== 1'b0 ||
                (d ? valid1 : valid0) !== 1'b0) begin
               failures++;
               $display("FAIL reset_state: dut%0d busy/done/valid not all 0", d);
            end
         end
      end
      @(negedge clk); rst = 1'b0; start = 1'b0;
      // reset in the middle of a transform
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 0 || done !== 0 || valid !== 0 || stage !== 0 ||
          addr_a !== 0 || addr_b !== 0 || tw_addr !== 0 || last !== 0) begin
         failures++;
         $display("FAIL reset_midrun: busy=%b valid=%b s=%0d a=%0d b=%0d tw=%0d want all 0",
                  busy, valid, stage, addr_a, addr_b, tw_addr);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_run();
      sel = 1'b0;
      run_seq(4, 1'b0, -1, 1'b0);
   endtask

   task automatic test_addr_spot();
      int idx[4], wa[4], wb[4], wt[4];
      int seen[64];
      idx = '{5, 35, 69, 167};
      wa  = '{10, 5, 9, 7};
      wb  = '{11, 7, 13, 39};
      wt  = '{0, 16, 8, 7};
      sel = 1'b0;
      run_seq(4, 1'b0, -1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap_a[idx[i]] != wa[i] || cap_b[idx[i]] != wb[i] || cap_tw[idx[i]] != wt[i]) begin
            failures++;
            $display("FAIL addr_spot[%0d]: a=%0d b=%0d tw=%0d want %0d %0d %0d",
                     idx[i], cap_a[idx[i]], cap_b[idx[i]], cap_tw[idx[i]], wa[i], wb[i], wt[i]);
         end
      end
      for (int s = 0; s < 6; s++) begin
         int bad;
         bad = 0;
         for (int j = 0; j < 64; j++) seen[j] = 0;
         for (int k = 0; k < 32; k++) begin
            seen[cap_a[s*32+k] % 64]++;
            seen[cap_b[s*32+k] % 64]++;
         end
         for (int j = 0; j < 64; j++) if (seen[j] != 1) bad++;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL addr_cover: stage %0d has %0d addresses not touched once, want 0", s, bad);
         end
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      run_seq(4, 1'b1, -1, 1'b0);
      run_seq(4, 1'b1, -1, 1'b0);
   endtask

   task automatic test_abort();
      sel = 1'b0;
      run_seq(4, 1'b0, 3*32 + 10, 1'b0);
      checks++;
      if (hs_total != 106) begin
         failures++;
         $display("FAIL abort_point: handshakes before abort %0d want 106", hs_total);
      end
      run_seq(4, 1'b0, -1, 1'b0);
      // start and abort together in IDLE: abort wins
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL start_abort_same: busy=%b valid=%b want 0 0", busy, valid);
      end
   endtask

   task automatic test_back_to_back();
      sel = 1'b1;
      run_seq(0, 1'b0, -1, 1'b1);
      run_seq(0, 1'b1, -1, 1'b1);
      sel = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; bfly_ready = 1'b1; sel = 1'b0;
      build_model();
      test_reset();
      test_full_run();
      test_addr_spot();
      test_backpressure();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
